// File: rtl/fb_write_arbiter.sv
// Pixel-write port owner for the 160x120 VGA framebuffer: full-screen clear sweep
// plus round-robin sharing of the port between two drawing requesters.
module fb_write_arbiter #(
    parameter int             XMAX      = 159,
    parameter int             YMAX      = 119,
    parameter int             CW        = 3,
    parameter logic [CW-1:0]  BG_COLOUR = '0
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    input  logic          req0,
    input  logic [7:0]    x0,
    input  logic [7:0]    y0,
    input  logic [CW-1:0] c0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [7:0]    x1,
    input  logic [7:0]    y1,
    input  logic [CW-1:0] c1,
    output logic          gnt1,
    output logic [7:0]    vga_x,
    output logic [7:0]    vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [7:0] XLAST = 8'(XMAX);
    localparam logic [7:0] YLAST = 8'(YMAX);

    state_t        state_q, state_d;
    logic [7:0]    cx_q, cx_d;
    logic [7:0]    cy_q, cy_d;
    logic          rr_q, rr_d;

    logic          g0_p0, g1_p0;
    logic          vld_p0;
    logic          done_p0;
    logic [7:0]    x_p0, y_p0;
    logic [CW-1:0] col_p0;

    function automatic logic in_range(input logic [7:0] px, input logic [7:0] py);
        return (px <= XLAST) && (py <= YLAST);
    endfunction

    // Stage 0: arbitration, clear sweep and selection of the next pixel
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        rr_d    = rr_q;
        g0_p0   = 1'b0;
        g1_p0   = 1'b0;
        vld_p0  = 1'b0;
        done_p0 = 1'b0;
        x_p0    = vga_x;
        y_p0    = vga_y;
        col_p0  = vga_colour;
        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d = CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (req0 && (!req1 || !rr_q)) begin
                    g0_p0 = 1'b1;
                    rr_d  = 1'b1;
                    if (in_range(x0, y0)) begin
                        vld_p0 = 1'b1;
                        x_p0   = x0;
                        y_p0   = y0;
                        col_p0 = c0;
                    end
                end else if (req1) begin
                    g1_p0 = 1'b1;
                    rr_d  = 1'b0;
                    if (in_range(x1, y1)) begin
                        vld_p0 = 1'b1;
                        x_p0   = x1;
                        y_p0   = y1;
                        col_p0 = c1;
                    end
                end
            end
            CLEAR: begin
                // The last sweep pixel is on the port this cycle; hand back next cycle.
                if (clear_done) begin
                    state_d = IDLE;
                end else begin
                    vld_p0 = 1'b1;
                    x_p0   = cx_q;
                    y_p0   = cy_q;
                    col_p0 = BG_COLOUR;
                    if (cx_q == XLAST) begin
                        cx_d = '0;
                        if (cy_q == YLAST) begin
                            done_p0 = 1'b1;
                        end else begin
                            cy_d = cy_q + 8'd1;
                        end
                    end else begin
                        cx_d = cx_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt0       = resetn & g0_p0;
    assign gnt1       = resetn & g1_p0;
    assign clear_busy = (state_q == CLEAR);

    // Stage 1: registered adapter write port and control state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            rr_q       <= 1'b0;
            vga_plot   <= 1'b0;
            clear_done <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            state_q    <= state_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            rr_q       <= rr_d;
            vga_plot   <= vld_p0;
            clear_done <= done_p0;
            vga_x      <= x_p0;
            vga_y      <= y_p0;
            vga_colour <= col_p0;
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter with a pixel-index level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_fb_write_arbiter;

    localparam int XMAX = 159;
    localparam int YMAX = 119;
    localparam int CW   = 3;
    localparam int NPIX = (XMAX + 1) * (YMAX + 1);

    logic          clk = 1'b0;
    logic          resetn;
    logic          clear_start;
    logic          clear_busy, clear_done;
    logic          req0, req1, gnt0, gnt1;
    logic [7:0]    x0, y0, x1, y1;
    logic [CW-1:0] c0, c1;
    logic [7:0]    vga_x, vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;

    fb_write_arbiter #(.XMAX(XMAX), .YMAX(YMAX), .CW(CW), .BG_COLOUR(3'd0)) dut (
        .clk(clk), .resetn(resetn), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .req0(req0), .x0(x0), .y0(y0), .c0(c0), .gnt0(gnt0),
        .req1(req1), .x1(x1), .y1(y1), .c1(c1), .gnt1(gnt1),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: clear progress as a linear pixel index
    bit m_clr, m_fin, m_ptr;
    int m_idx;
    int e_plot, e_x, e_y, e_c, e_done;

    // values seen at the most recent sampling point
    int s_g0, s_g1, s_busy, s_done, s_plot, s_x, s_y, s_c;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clr = 0; m_fin = 0; m_ptr = 0; m_idx = 0;
        e_plot = 0; e_x = 0; e_y = 0; e_c = 0; e_done = 0;
    endtask

    // sample, compare against the model, then advance the model by one clock
    task automatic compare_and_advance();
        int eg0, eg1, busy;
        s_g0 = int'(gnt0); s_g1 = int'(gnt1); s_busy = int'(clear_busy);
        s_done = int'(clear_done); s_plot = int'(vga_plot);
        s_x = int'(vga_x); s_y = int'(vga_y); s_c = int'(vga_colour);
        if (!resetn) begin
            model_reset();
            eg0 = 0; eg1 = 0; busy = 0;
        end else begin
            busy = (m_clr || m_fin) ? 1 : 0;
            eg0 = (!busy && !clear_start && req0 && (!req1 || !m_ptr)) ? 1 : 0;
            eg1 = (!busy && !clear_start && req1 && eg0 == 0) ? 1 : 0;
        end
        chk("gnt0", s_g0, eg0);
        chk("gnt1", s_g1, eg1);
        chk("clear_busy", s_busy, busy);
        chk("clear_done", s_done, e_done);
        chk("vga_plot", s_plot, e_plot);
        chk("vga_x", s_x, e_x);
        chk("vga_y", s_y, e_y);
        chk("vga_colour", s_c, e_c);
        if (!resetn) return;
        e_done = 0;
        e_plot = 0;
        if (m_clr) begin
            e_plot = 1;
            e_x = m_idx % (XMAX + 1);
            e_y = m_idx / (XMAX + 1);
            e_c = 0;
            e_done = (m_idx == NPIX - 1) ? 1 : 0;
            m_idx++;
            if (m_idx == NPIX) begin
                m_clr = 0;
                m_fin = 1;
            end
        end else if (m_fin) begin
            m_fin = 0;
        end else if (clear_start) begin
            m_clr = 1;
            m_idx = 0;
        end else if (eg0 == 1 || eg1 == 1) begin
            int px, py, pc;
            px = eg0 == 1 ? int'(x0) : int'(x1);
            py = eg0 == 1 ? int'(y0) : int'(y1);
            pc = eg0 == 1 ? int'(c0) : int'(c1);
            m_ptr = (eg0 == 1);
            if (px <= XMAX && py <= YMAX) begin
                e_plot = 1; e_x = px; e_y = py; e_c = pc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    // start a clear and advance until the given number of clear pixels have shown
    task automatic start_clear_and_wait(input int npix);
        int seen = 0;
        int guard = 0;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        while (seen < npix && guard < NPIX + 10) begin
            tick();
            if (s_plot == 1) seen++;
            guard++;
        end
        chk("clear_progress_timeout", seen, npix);
    endtask

    initial begin
        int plots, guard, wrap_ok, gnt_in_clear;
        int first_x, first_y, last_x, last_y, prev_x, prev_y, col_bad;
        int gseq[5];
        int xseq[5];
        int pseq[5];

        resetn = 1'b0; clear_start = 1'b0;
        req0 = 1'b0; x0 = '0; y0 = '0; c0 = '0;
        req1 = 1'b0; x1 = '0; y1 = '0; c1 = '0;
        model_reset();
        tick(); tick();
        chk("reset_plot", s_plot, 0);
        chk("reset_busy", s_busy, 0);
        resetn = 1'b1;
        tick(); tick();

        // full-screen clear
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        plots = 0; guard = 0; wrap_ok = 0; col_bad = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1; prev_x = -1; prev_y = -1;
        while (guard < NPIX + 10) begin
            tick();
            guard++;
            if (s_plot == 1) begin
                if (plots == 0) begin first_x = s_x; first_y = s_y; end
                if (prev_x == 159 && prev_y == 0 && s_x == 0 && s_y == 1) wrap_ok = 1;
                if (s_c != 0) col_bad++;
                prev_x = s_x; prev_y = s_y;
                plots++;
            end
            if (s_done == 1) begin
                last_x = s_x; last_y = s_y;
                break;
            end
        end
        chk("clear_plot_count", plots, 19200);
        chk("clear_first_x", first_x, 0);
        chk("clear_first_y", first_y, 0);
        chk("clear_wrap_159_0_to_0_1", wrap_ok, 1);
        chk("clear_last_x", last_x, 159);
        chk("clear_last_y", last_y, 119);
        chk("clear_colour_nonzero", col_bad, 0);
        tick();
        chk("clear_busy_after_done", s_busy, 0);
        tick();

        // both requesters held: alternating grants, one pixel per cycle
        req0 = 1'b1; x0 = 8'd10; y0 = 8'd20; c0 = 3'd1;
        req1 = 1'b1; x1 = 8'd30; y1 = 8'd40; c1 = 3'd6;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin req0 = 1'b0; req1 = 1'b0; end
            tick();
            gseq[i] = s_g1 == 1 ? 1 : (s_g0 == 1 ? 0 : -1);
            xseq[i] = s_x;
            pseq[i] = s_plot;
        end
        chk("rr_gnt_0", gseq[0], 0);
        chk("rr_gnt_1", gseq[1], 1);
        chk("rr_gnt_2", gseq[2], 0);
        chk("rr_gnt_3", gseq[3], 1);
        chk("rr_plot_1", pseq[1], 1);
        chk("rr_x_1", xseq[1], 10);
        chk("rr_x_2", xseq[2], 30);
        chk("rr_x_3", xseq[3], 10);
        chk("rr_plot_4", pseq[4], 1);
        chk("rr_x_4", xseq[4], 30);
        chk("rr_colour_4", s_c, 6);
        tick();

        // request stalled by a clear until the cycle after clear_done
        start_clear_and_wait(100);
        req0 = 1'b1; x0 = 8'd7; y0 = 8'd8; c0 = 3'd2;
        gnt_in_clear = 0; guard = 0;
        while (guard < NPIX + 10) begin
            tick();
            guard++;
            if (s_g0 == 1) gnt_in_clear++;
            if (s_done == 1) break;
        end
        chk("stall_done_seen", s_done, 1);
        chk("stall_gnt_during_clear", gnt_in_clear, 0);
        tick();
        chk("stall_gnt_after_done", s_g0, 1);
        req0 = 1'b0;
        tick();
        chk("stall_plot", s_plot, 1);
        chk("stall_x", s_x, 7);
        chk("stall_y", s_y, 8);
        chk("stall_colour", s_c, 2);

        // out-of-range pixel is consumed but not plotted
        req1 = 1'b1; x1 = 8'd160; y1 = 8'd5; c1 = 3'd3;
        tick();
        chk("oor_gnt1", s_g1, 1);
        req1 = 1'b0;
        tick();
        chk("oor_plot", s_plot, 0);
        chk("oor_x_held", s_x, 7);
        tick();
        chk("oor_gnt1_once", s_g1, 0);

        // asynchronous reset in the middle of a clear
        start_clear_and_wait(5000);
        req0 = 1'b1; x0 = 8'd3; y0 = 8'd4; c0 = 3'd5;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_plot", int'(vga_plot), 0);
        chk("async_rst_x", int'(vga_x), 0);
        chk("async_rst_y", int'(vga_y), 0);
        chk("async_rst_busy", int'(clear_busy), 0);
        chk("async_rst_done", int'(clear_done), 0);
        chk("async_rst_gnt0", int'(gnt0), 0);
        tick();
        req0 = 1'b0;
        tick();
        resetn = 1'b1;
        plots = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            plots += s_plot + s_busy;
        end
        chk("post_rst_no_clear", plots, 0);
        req0 = 1'b1;
        tick();
        chk("post_rst_gnt0", s_g0, 1);
        req0 = 1'b0;
        tick();
        chk("post_rst_plot", s_plot, 1);
        chk("post_rst_x", s_x, 3);
        chk("post_rst_y", s_y, 4);
        chk("post_rst_colour", s_c, 5);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
